muldiv_ctrl: RTL

- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. Owns the HI/LO architectural registers.
- Sits beside the single-cycle ALU. The decoder issues a start pulse, and the core stalls on busy until done.
- The iterative datapath is an internal shift-add multiplier and a restoring divider working on operand magnitudes, followed by a sign-fix cycle.

---
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Bus bundle between the decode/stall logic and the multiply/divide sequencer.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             abort;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, SrcA, SrcB, abort, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, SrcA, SrcB, abort, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO (shift-add multiply, restoring divide).
// Optional MULDIV_ZERO_BYPASS_EN: zero-operand operations skip the iteration phase.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               is_div_q, neg_res_q, neg_rem_q, dbz_q;
    logic [WIDTH-1:0]   opnd_q, src_a_q;
    logic [2*WIDTH-1:0] prod_q;

    logic               busy, launch, is_signed, neg_a, neg_b, div_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH-1:0] div_shift, prod_step, prod_signed;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
`ifdef MULDIV_ZERO_BYPASS_EN
    logic               skip;
`endif

    assign busy      = (state == CALC) || (state == FIX);
    assign launch    = ((state == IDLE) || (state == DONE)) && bus.start && !bus.abort;
    assign is_signed = !bus.op[0];
    assign neg_a     = is_signed && bus.SrcA[WIDTH-1];
    assign neg_b     = is_signed && bus.SrcB[WIDTH-1];
    assign mag_a     = neg_a ? -bus.SrcA : bus.SrcA;
    assign mag_b     = neg_b ? -bus.SrcB : bus.SrcB;
    assign div_zero  = bus.op[1] && (bus.SrcB == '0);
`ifdef MULDIV_ZERO_BYPASS_EN
    assign skip      = div_zero || (!bus.op[1] && ((bus.SrcA == '0) || (bus.SrcB == '0)));
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (launch) begin
`ifdef MULDIV_ZERO_BYPASS_EN
                    state_nxt = skip ? FIX : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (bus.abort)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))
                    state_nxt = FIX;
            end
            FIX:  state_nxt = bus.abort ? IDLE : DONE;
        endcase
    end

    // Multiply keeps {partial product, remaining multiplier bits}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {prod_q[2*WIDTH-2:0], 1'b0};
        div_diff  = {prod_q[2*WIDTH-1], div_shift[2*WIDTH-1:WIDTH]} - {1'b0, opnd_q};
        if (is_div_q)
            prod_step = div_diff[WIDTH] ? div_shift
                                        : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
        else
            prod_step = {mul_sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        prod_signed = neg_res_q ? -prod_q : prod_q;
        fix_hi      = prod_signed[2*WIDTH-1:WIDTH];
        fix_lo      = prod_signed[WIDTH-1:0];
        if (is_div_q) begin
            if (dbz_q) begin
                fix_lo = '1;
                fix_hi = src_a_q;
            end else begin
                fix_lo = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
                fix_hi = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            if (launch)
                cnt <= '0;
            else if (state == CALC)
                cnt <= cnt + CNT_W'(1);
            if ((state == FIX) && !bus.abort) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if (!busy && !bus.start) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            is_div_q  <= bus.op[1];
            neg_res_q <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
            dbz_q     <= div_zero;
            src_a_q   <= bus.SrcA;
            opnd_q    <= bus.op[1] ? mag_b : mag_a;
            prod_q    <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
`ifdef MULDIV_ZERO_BYPASS_EN
            if (skip && !bus.op[1])
                prod_q <= '0;
`endif
        end else if (state == CALC) begin
            prod_q <= prod_step;
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = (state == DONE);
    assign bus.div_by_zero = (state == DONE) && dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
